uart_command_responder: RTL
===========================

UART_COMMAND_RESPONDER -- requirements
Module: uart_command_responder

Interface
REQ-001 Parameter FX, default 245, fighting-box left edge x (pixels).
REQ-002 Parameter FY, default 230, fighting-box top edge y (pixels).
REQ-003 Parameter BOX, default 150, fighting-box side length (pixels).
REQ-004 Parameter HEART, default 16, player sprite side length (pixels).
REQ-005 Parameter STEP, default 4, pixels moved per movement command.
REQ-006 clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 rx_data  input  8  received byte from UART receiver.
REQ-009 rx_receive  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-010 tx_idle  input  1  high when UART transmitter can accept a byte.
REQ-011 tx_data  output  8  echo byte to UART transmitter.
REQ-012 tx_transmit  output  1  one-cycle start strobe to UART transmitter.
REQ-013 pos_x  output  16  player sprite top-left x.
REQ-014 pos_y  output  16  player sprite top-left y.
REQ-015 color  output  12  player sprite RGB444 color.
REQ-016 cmd_count  output  16  count of accepted rx bytes, wraps 0xFFFF->0.
REQ-017 echo_ovf  output  1  sticky flag: an echo byte was dropped.

Function
REQ-018 Decode on rx_receive=1; outputs update on the next rising edge (1-cycle latency).
REQ-019 0x77 'w': pos_y -= STEP, clamped at FY; echo 0x57.
REQ-020 0x73 's': pos_y += STEP, clamped at FY+BOX-HEART (364 default); echo 0x53.
REQ-021 0x61 'a': pos_x -= STEP, clamped at FX; echo 0x41.
REQ-022 0x64 'd': pos_x += STEP, clamped at FX+BOX-HEART (379 default); echo 0x44.
REQ-023 Clamp computed at 17-bit width; no unsigned wrap on subtract near 0.
REQ-024 0x63 'c' -> color 0x0FF, echo 0x43; 0x6D 'm' -> 0xF0F, echo 0x4D; 0x79 'y' -> 0xFF0, echo 0x59; 0x20 ' ' -> 0xFFF, echo 0x5A.
REQ-025 Any other byte: position/color unchanged; echo 0x3F '?'.
REQ-026 cmd_count increments by 1 for every rx_receive strobe, including unknown bytes.
REQ-027 Echo bytes queue in a 4-entry FIFO, preserving order.
REQ-028 FIFO full on push with no same-cycle pop: echo dropped, echo_ovf set, command still applied.
REQ-029 Push and pop in same cycle while full: both occur, no drop.
REQ-030 TX FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-031 IDLE -> SEND when FIFO non-empty and tx_idle=1.
REQ-032 SEND: tx_data = FIFO head, tx_transmit = 1 for exactly one cycle, FIFO pops; -> WAIT_BUSY.
REQ-033 WAIT_BUSY -> WAIT_DONE when tx_idle=0; WAIT_DONE -> IDLE when tx_idle=1.
REQ-034 tx_data holds last sent value outside SEND; tx_transmit = 0 in all states except SEND.
REQ-035 At most one tx_transmit strobe per transmitter busy period.

Reset
REQ-036 rst_n=0 asynchronously: pos_x=312, pos_y=297 (box centre, defaults), color=0xFFF, cmd_count=0, echo_ovf=0, tx_data=0x00, tx_transmit=0, FIFO empty, FSM IDLE.
REQ-037 Reset during a transmission aborts the queue; no further strobe until a new byte arrives after release.
REQ-038 echo_ovf clears only on reset.

Verification
REQ-039 Reset, then rx 0x64 with tx_idle=1 -> next cycle pos_x=316; SEND strobe with tx_data=0x44; cmd_count=1.
REQ-040 40 x 0x77 -> pos_y saturates at 230; 40 x 0x61 -> pos_x saturates at 245; no wrap.
REQ-041 rx 0x6D then 0x41 -> color=0xF0F, then echoes 0x4D, 0x3F in order; color unchanged by 0x41.
REQ-042 tx_idle held 0, send 6 bytes -> 4 queued, echo_ovf=1, cmd_count=6, all commands applied; release tx_idle -> exactly 4 strobes, one per idle period.
REQ-043 Assert rst_n=0 mid-WAIT_DONE with 3 queued -> all outputs at reset values immediately; after release with no rx, no tx_transmit.

Source files
------------

// File: rtl/uart_command_responder.sv
// ---------------------------------------------------------------------------
// uart_command_responder
//
// Turns single-byte commands from a UART receiver into sprite movement and
// colour changes, and returns one echo byte per command to a UART
// transmitter through a 4-entry FIFO.
//
// Ports
//   clk          system clock, all state changes on its rising edge
//   rst_n        asynchronous active-low reset
//   rx_data      received byte, valid while rx_receive is high
//   rx_receive   one-cycle strobe from the receiver
//   tx_idle      high when the transmitter can take a byte
//   tx_data      echo byte presented to the transmitter (holds last sent)
//   tx_transmit  one-cycle start strobe to the transmitter
//   pos_x/pos_y  sprite top-left corner, kept inside the fighting box
//   color        sprite colour, RGB444
//   cmd_count    number of received bytes, wraps at 16 bits
//   echo_ovf     sticky: an echo byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module uart_command_responder #(
    parameter int FX    = 245,
    parameter int FY    = 230,
    parameter int BOX   = 150,
    parameter int HEART = 16,
    parameter int STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_receive,
    input  logic        tx_idle,
    output logic [7:0]  tx_data,
    output logic        tx_transmit,
    output logic [15:0] pos_x,
    output logic [15:0] pos_y,
    output logic [11:0] color,
    output logic [15:0] cmd_count,
    output logic        echo_ovf
);

    localparam logic [15:0] X_MIN  = 16'(FX);
    localparam logic [15:0] X_MAX  = 16'(FX + BOX - HEART);
    localparam logic [15:0] Y_MIN  = 16'(FY);
    localparam logic [15:0] Y_MAX  = 16'(FY + BOX - HEART);
    localparam logic [15:0] X_RST  = 16'(FX + (BOX - HEART) / 2);
    localparam logic [15:0] Y_RST  = 16'(FY + (BOX - HEART) / 2);
    localparam logic [16:0] STEP17 = 17'(STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } tx_state_t;

    // Clamped moves use a 17-bit view so a step below the lower bound can
    // never wrap around to a large unsigned value.
    function automatic logic [15:0] step_down(input logic [15:0] v, input logic [15:0] lo);
        if ({1'b0, v} < ({1'b0, lo} + STEP17)) return lo;
        return 16'({1'b0, v} - STEP17);
    endfunction

    function automatic logic [15:0] step_up(input logic [15:0] v, input logic [15:0] hi);
        logic [16:0] sum;
        sum = {1'b0, v} + STEP17;
        if (sum > {1'b0, hi}) return hi;
        return sum[15:0];
    endfunction

    tx_state_t   r_state, w_state_next;
    logic [15:0] r_pos_x, r_pos_y, r_cmd_count;
    logic [11:0] r_color;
    logic        r_echo_ovf;
    logic [7:0]  r_tx_data;

    logic [7:0]  r_fifo [4];
    logic [1:0]  r_wr_ptr, r_rd_ptr;
    logic [2:0]  r_count;

    logic [15:0] w_x_next, w_y_next;
    logic [11:0] w_color_next;
    logic [7:0]  w_echo;
    logic        w_full, w_empty, w_push, w_pop, w_load_tx;

    // Command decode: next position/colour and the echo byte for rx_data.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_x_next     = r_pos_x;
        w_y_next     = r_pos_y;
        w_color_next = r_color;
        w_echo       = 8'h3F;
        case (rx_data)
            8'h77: begin w_y_next = step_down(r_pos_y, Y_MIN); w_echo = 8'h57; end
            8'h73: begin w_y_next = step_up(r_pos_y, Y_MAX);   w_echo = 8'h53; end
            8'h61: begin w_x_next = step_down(r_pos_x, X_MIN); w_echo = 8'h41; end
            8'h64: begin w_x_next = step_up(r_pos_x, X_MAX);   w_echo = 8'h44; end
            8'h63: begin w_color_next = 12'h0FF; w_echo = 8'h43; end
            8'h6D: begin w_color_next = 12'hF0F; w_echo = 8'h4D; end
            8'h79: begin w_color_next = 12'hFF0; w_echo = 8'h59; end
            8'h20: begin w_color_next = 12'hFFF; w_echo = 8'h5A; end
            default: ;
        endcase
    end

    assign w_full  = (r_count == 3'd4);
    assign w_empty = (r_count == 3'd0);
    assign w_pop   = (r_state == S_SEND);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = rx_receive && (!w_full || w_pop);

    // Transmit FSM: next state and strobe.
    always_comb begin
        w_state_next = r_state;
        tx_transmit  = 1'b0;
        case (r_state)
            S_IDLE:      if (!w_empty && tx_idle) w_state_next = S_SEND;
            S_SEND: begin
                tx_transmit  = 1'b1;
                w_state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: if (!tx_idle) w_state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (tx_idle)  w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
        w_load_tx = (r_state == S_IDLE) && (w_state_next == S_SEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pos_x     <= X_RST;
            r_pos_y     <= Y_RST;
            r_color     <= 12'hFFF;
            r_cmd_count <= 16'd0;
            r_echo_ovf  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_wr_ptr    <= 2'd0;
            r_rd_ptr    <= 2'd0;
            r_count     <= 3'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register here
            // updating from the same pre-edge values.
            r_state <= w_state_next;
            if (rx_receive) begin
                r_pos_x     <= w_x_next;
                r_pos_y     <= w_y_next;
                r_color     <= w_color_next;
                r_cmd_count <= r_cmd_count + 16'd1;
            end
            if (rx_receive && w_full && !w_pop) r_echo_ovf <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count <= r_count + 3'(w_push) - 3'(w_pop);
            // Latched on entry to SEND so the byte stays put after the pop.
            if (w_load_tx) r_tx_data <= r_fifo[r_rd_ptr];
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; the reset pointers
    // and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_echo;
    end

    assign tx_data   = r_tx_data;
    assign pos_x     = r_pos_x;
    assign pos_y     = r_pos_y;
    assign color     = r_color;
    assign cmd_count = r_cmd_count;
    assign echo_ovf  = r_echo_ovf;

endmodule
